tree_leaf_stage: RTL
====================

// Module: tree_leaf_stage
// PURPOSE
//  Leaf-level buffered stage for the generated module trees: the block a tree node instantiates as a child.
//  Accepts a valid/ready byte stream and buffers it in a DEPTH-entry FIFO.
//  Tags each beat with this leaf's ID and a per-leaf sequence number.
//  Counts delivered beats so benches can check traffic through every leaf of the hierarchy.
// PARAMETERS
//  DATA_W   8   payload width
//  DEPTH    4   FIFO entries; power of 2, >= 2
//  LEAF_ID  0   constant tag on every output beat (0..2**ID_W-1)
//  ID_W     4   width of leaf tag
//  SEQ_W    8   sequence-number width; wraps modulo 2**SEQ_W
//  CNT_W    16  delivered-beat counter width
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  clear        in   1       synchronous flush: empties FIFO, zeroes seq and counters
//  in_valid     in   1       upstream beat valid
//  in_ready     out  1       stage can accept (FIFO not full)
//  in_data      in   DATA_W  upstream payload
//  out_valid    out  1       FIFO head valid
//  out_ready    in   1       downstream accepts
//  out_data     out  DATA_W  head payload
//  out_leaf_id  out  ID_W    always LEAF_ID
//  out_seq      out  SEQ_W   sequence number stamped at enqueue
//  beat_count   out  CNT_W   number of completed output handshakes
//  count_sat    out  1       sticky: beat_count reached 2**CNT_W-1
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): FIFO empty, wr/rd ptr=0, next_seq=0, beat_count=0,
//  count_sat=0; outputs in_ready=1, out_valid=0, out_data=0, out_seq=0.
//  Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same edge.
//  in_ready = !full, derived from registered occupancy only (no comb path from out_ready).
//  Full + pop in same cycle: pop happens, push refused (in_ready was 0); slot is free next cycle.
//  Empty + push: out_valid rises the following cycle (latency 1); no bypass.
//  Simultaneous push and pop when neither full nor empty: occupancy unchanged, both complete.
//  Occupancy held in $clog2(DEPTH)+1 bits; pointers wrap at DEPTH.
//  Seq: pushed beat takes next_seq; next_seq increments on each push and wraps 2**SEQ_W-1 -> 0.
//  beat_count increments on each pop and saturates at all-ones; count_sat set then and sticky until rst/clear.
//  out_data/out_seq stable while out_valid=1 & out_ready=0 (AXI-style hold).
//  out_data/out_seq are don't-care-but-stable when out_valid=0; hold last head value, reset value 0.
//  clear has priority over push and pop in the same cycle: nothing is accepted or delivered.
//  After clear: state equals post-reset on the next cycle.
//  Reset mid-stream discards all buffered beats; no beat is delivered after rst asserts.
//  Upstream must hold in_data while in_valid=1 & in_ready=0; violations are not checked in RTL.
// STRUCTURE
//  Package tree_leaf_pkg:
//  - typedef struct packed {data, seq} leaf_entry_t (parameterised widths passed via module)
//  - localparam defaults DATA_W_DEF=8, SEQ_W_DEF=8
//  Sub-module tree_leaf_fifo: generic sync FIFO (push/pop/full/empty/clear), width = DATA_W+SEQ_W.
//  Top: seq generator, beat counter, saturation flag, tag output.
// TESTING
//  1 rst, then push 0xA1,0xA2 with out_ready=1 -> out 0xA1/seq0 then 0xA2/seq1, one cycle after each push;
//    beat_count=2.
//  2 out_ready=0, push 5 beats (DEPTH=4) -> in_ready=0 after 4th, 5th held.
//    Raise out_ready -> all 5 delivered in order, seq 0..4.
//  3 full FIFO, in_valid=1 & out_ready=1 same cycle -> one pop, no push that cycle; push completes next cycle.
//  4 SEQ_W=8, 257 beats -> beat 256 has seq 0.
//    CNT_W=4, 16 beats -> beat_count=15, count_sat=1, stays 1.
//  5 3 beats buffered, clear with in_valid & out_ready high -> no handshake that cycle.
//    Next cycle out_valid=0, beat_count=0, next push seq 0.
//  6 rst asserted mid-transfer with 2 beats buffered -> out_valid=0 immediately (async), in_ready=1.

Source files
------------

// File: rtl/tree_leaf_pkg.sv
// Shared types and defaults for the leaf stage of the generated module trees.
// The entry type matches the default widths; the top declares its own entry type for other widths.
package tree_leaf_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int SEQ_W_DEF  = 8;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [SEQ_W_DEF-1:0]  seq;
   } leaf_entry_t;

   // One extra bit lets a full FIFO be told apart from an empty one.
   function automatic int occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/tree_leaf_fifo.sv
// Generic synchronous FIFO with flush. dout shows the head entry; when empty it holds the
// last popped entry (zero after reset or clear).
module tree_leaf_fifo
   import tree_leaf_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = occ_w(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [OW-1:0] occ_q, occ_d;
   logic [W-1:0]  last_q;
   logic          do_push, do_pop;

   assign full    = (occ_q == OW'(DEPTH));
   assign empty   = (occ_q == '0);
   assign do_push = push & ~full & ~clear;
   assign do_pop  = pop & ~empty & ~clear;
   assign dout    = empty ? last_q : mem_q[rd_ptr_q];

   always_comb begin
      occ_d = occ_q;
      if (clear)                occ_d = '0;
      else if (do_push & ~do_pop) occ_d = occ_q + OW'(1);
      else if (do_pop & ~do_push) occ_d = occ_q - OW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         last_q   <= '0;
      end else begin
         occ_q <= occ_d;
         if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
         end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) begin
               rd_ptr_q <= rd_ptr_q + AW'(1);
               last_q   <= mem_q[rd_ptr_q];
            end
         end
      end
   end

   // Storage needs no reset: it is only read through dout while occupied.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/tree_leaf_stage.sv
// Leaf stage: buffers a valid/ready byte stream, stamps each beat with leaf ID and sequence
// number at enqueue, and counts delivered beats with a sticky saturation flag.
module tree_leaf_stage
   import tree_leaf_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH   = 4,
   parameter int LEAF_ID = 0,
   parameter int ID_W    = 4,
   parameter int SEQ_W   = SEQ_W_DEF,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ID_W-1:0]   out_leaf_id,
   output logic [SEQ_W-1:0]  out_seq,
   output logic [CNT_W-1:0]  beat_count,
   output logic              count_sat
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SEQ_W-1:0]  seq;
   } entry_t;

   entry_t           wr_entry, rd_entry;
   logic             full, empty, push, pop;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   // Ready depends only on registered occupancy, so no comb path from out_ready.
   assign in_ready = ~full;
   assign out_valid = ~empty;
   assign push = in_valid & in_ready & ~clear;
   assign pop  = out_valid & out_ready & ~clear;

   assign wr_entry.data = in_data;
   assign wr_entry.seq  = seq_q;

   tree_leaf_fifo #(
      .W     (DATA_W + SEQ_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .din   (wr_entry),
      .dout  (rd_entry),
      .full  (full),
      .empty (empty)
   );

   assign out_data    = rd_entry.data;
   assign out_seq     = rd_entry.seq;
   assign out_leaf_id = ID_W'(LEAF_ID);
   assign beat_count  = cnt_q;
   assign count_sat   = sat_q;

   always_comb begin
      seq_d = seq_q;
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clear) begin
         seq_d = '0;
         cnt_d = '0;
         sat_d = 1'b0;
      end else begin
         if (push) seq_d = seq_q + SEQ_W'(1);
         if (pop && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
         sat_d = sat_q | (&cnt_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q <= '0;
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         seq_q <= seq_d;
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

endmodule
